// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Arbitrates CPU and VGA 32-bit accesses onto a 16-bit RAM port,
//            splitting each word into a low and a high halfword beat.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        vga_req,
    input  logic [31:0] vga_addr,
    output logic [31:0] vga_rdata,
    output logic        vga_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LO   = 2'd1;
    localparam logic [1:0] c_HI   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic c_OWN_CPU = 1'b0;
    localparam logic c_OWN_VGA = 1'b1;

    logic [1:0]  r_state;
    logic        r_owner;
    logic        r_last_served;
    logic        r_we;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [15:0] r_lo_buf;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_vga_rdata;

    logic        w_grant_vga;
    logic        w_unused;

    // Byte-lane bits are don't-care: accesses are always word aligned.
    assign w_unused = ^{cpu_addr[1:0], vga_addr[1:0]};

    // On a tie, FAIR hands the grant to whoever was not served last.
    always_comb begin
        w_grant_vga = vga_req;
        if (cpu_req && vga_req) begin
            w_grant_vga = FAIR ? (r_last_served == c_OWN_CPU) : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_owner       <= c_OWN_CPU;
            r_last_served <= c_OWN_VGA;
            r_we          <= 1'b0;
            r_addr        <= 30'd0;
            r_wdata       <= 32'd0;
            r_lo_buf      <= 16'd0;
            r_cpu_rdata   <= 32'd0;
            r_vga_rdata   <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cpu_req || vga_req) begin
                        r_state <= c_LO;
                        if (w_grant_vga) begin
                            r_owner <= c_OWN_VGA;
                            r_we    <= 1'b0;
                            r_addr  <= vga_addr[31:2];
                            r_wdata <= 32'd0;
                        end else begin
                            r_owner <= c_OWN_CPU;
                            r_we    <= cpu_we;
                            r_addr  <= cpu_addr[31:2];
                            r_wdata <= cpu_wdata;
                        end
                    end
                end
                c_LO: begin
                    if (mem_ack) begin
                        r_lo_buf <= mem_rdata;
                        r_state  <= c_HI;
                    end
                end
                c_HI: begin
                    if (mem_ack) begin
                        // Commit the whole word at once so rdata never shows a half-updated value.
                        if (!r_we) begin
                            if (r_owner == c_OWN_VGA) begin
                                r_vga_rdata <= {mem_rdata, r_lo_buf};
                            end else begin
                                r_cpu_rdata <= {mem_rdata, r_lo_buf};
                            end
                        end
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_last_served <= r_owner;
                    r_state       <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 16'd0;
        if (r_state == c_LO) begin
            mem_addr  = {r_addr, 2'b00};
            mem_wdata = r_wdata[15:0];
        end else if (r_state == c_HI) begin
            mem_addr  = {r_addr, 2'b10};
            mem_wdata = r_wdata[31:16];
        end
    end

    assign mem_req   = (r_state == c_LO) || (r_state == c_HI);
    assign mem_we    = mem_req && r_we;
    assign cpu_ack   = (r_state == c_DONE) && (r_owner == c_OWN_CPU);
    assign vga_ack   = (r_state == c_DONE) && (r_owner == c_OWN_VGA);
    assign cpu_rdata = r_cpu_rdata;
    assign vga_rdata = r_vga_rdata;

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: FAIR, default 1, 1 = round-robin between CPU and VGA, 0 = fixed CPU priority.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-005 cpu_we  input  1  CPU write (1) / read (0), sampled with grant.
REQ-006 cpu_addr  input  32  CPU byte address, bits [1:0] ignored.
REQ-007 cpu_wdata  input  32  CPU write word.
REQ-008 cpu_rdata  output  32  CPU read word.
REQ-009 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-010 vga_req  input  1  VGA read request, held until vga_ack.
REQ-011 vga_addr  input  32  VGA byte address, bits [1:0] ignored.
REQ-012 vga_rdata  output  32  VGA read word.
REQ-013 vga_ack  output  1  one-cycle completion pulse to VGA.
REQ-014 mem_req  output  1  halfword access request to RAM controller.
REQ-015 mem_we  output  1  halfword write enable.
REQ-016 mem_addr  output  32  halfword byte address.
REQ-017 mem_wdata  output  16  halfword write data.
REQ-018 mem_rdata  input  16  halfword read data, valid with mem_ack.
REQ-019 mem_ack  input  1  halfword access complete.

Function
REQ-020 The FSM SHALL have states IDLE, LO, HI, DONE.
REQ-021 IDLE: if either request is high, grant one, latch owner, we (VGA forced 0), addr[31:2], wdata, then go to LO; otherwise stay in IDLE.
REQ-022 Grant with FAIR=1: a single requester wins; on simultaneous requests, the requester not served last wins. With FAIR=0, CPU always wins ties.
REQ-023 LO: mem_req=1, mem_addr={addr[31:2],2'b00}, mem_wdata=wdata[15:0]; on mem_ack, capture mem_rdata into bits [15:0] (reads), then go to HI.
REQ-024 HI: mem_req=1, mem_addr={addr[31:2],2'b10}, mem_wdata=wdata[31:16]; on mem_ack, capture into bits [31:16], then go to DONE.
REQ-025 mem_req SHALL stay high continuously through LO and HI; mem_we equals the latched we in LO/HI and is 0 elsewhere.
REQ-026 DONE: pulse the owner's ack for exactly one cycle, update last-served to owner, go to IDLE; the non-owner ack stays 0.
REQ-027 Read data SHALL be written to the owner's rdata register only; cpu_rdata/vga_rdata hold until that requester's next completed read. Writes leave rdata unchanged.
REQ-028 Latency: with mem_ack high on the first cycle of each beat, ack asserts 3 cycles after the IDLE edge that samples req; each mem_ack wait cycle adds 1.
REQ-029 mem_ack SHALL be ignored in IDLE and DONE.
REQ-030 Request dropped mid-transaction: the transaction completes and ack still pulses.
REQ-031 Request still high in the IDLE cycle after ack: treated as a new request.
REQ-032 No combinational path from any input to any output; all outputs decode registered state.

Reset
REQ-033 rst_n low SHALL immediately force IDLE and set mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ack=0, vga_ack=0, cpu_rdata=0, vga_rdata=0, last-served=VGA.
REQ-034 Reset mid-transaction aborts it with no ack; the first grant after release follows REQ-022 with last-served=VGA.

Verification
REQ-035 CPU read 0x100, mem_ack immediate, mem_rdata 0xBEEF then 0xDEAD -> mem_addr 0x100 then 0x102, cpu_rdata=0xDEADBEEF, cpu_ack one cycle, 3 cycles after sample.
REQ-036 CPU write 0x204 data 0x12345678 -> mem_we=1, beats (0x204,0x5678),(0x206,0x1234), cpu_rdata unchanged.
REQ-037 FAIR=1, cpu_req and vga_req held high from reset -> grants alternate CPU, VGA, CPU, VGA; FAIR=0 -> CPU only.
REQ-038 mem_ack delayed 2 cycles per beat -> mem_req stays high and addresses stable, ack 7 cycles after sample.
REQ-039 rst_n pulsed low during HI -> outputs reset asynchronously, no ack, clean transaction after release.
